// File: rtl/tdc_pkg.sv
// Shared TDC definitions: coarse-count width, saturation code and event-word layout.
package tdc_pkg;

  localparam int unsigned COARSE_W  = 12;
  localparam logic [COARSE_W-1:0] COARSE_SAT = 12'hFFF;
  localparam int unsigned SEQ_W_DEF = 8;

  // Event word as seen by the consumer: sequence number above the coarse count.
  typedef struct packed {
    logic [SEQ_W_DEF-1:0] seq;
    logic [COARSE_W-1:0]  count;
  } tdc_evt_t;

  function automatic int unsigned evt_w(input int unsigned seq_w);
    return seq_w + COARSE_W;
  endfunction

endpackage

// File: rtl/tdc_eb_fifo.sv
// Event storage for the TDC buffer: distributed RAM with asynchronous show-ahead read.
// Push/pop arrive pre-qualified (pop only when non-empty, push only when a slot is free).
module tdc_eb_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_fill
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [FW-1:0] r_fill;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_fill <= r_fill + FW'(1);
        2'b01:   r_fill <= r_fill - FW'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_fill  = r_fill;

endmodule

// File: rtl/tdc_event_buffer.sv
// TDC event buffer: tags coarse measurements with a sequence number and queues them.
// Optional build macro TDC_EB_SAT_FILTER_EN drops saturated (12'hFFF) counts before storage.
module tdc_event_buffer
  import tdc_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SEQ_W = 8
) (
  input  logic                        clk_EB,
  input  logic                        reset_n_EB,
  input  logic                        Valid_CC,
  input  logic [COARSE_W-1:0]         CountOutCC,
  input  logic                        flush_EB,
  output logic                        out_valid_EB,
  input  logic                        out_ready_EB,
  output logic [SEQ_W+COARSE_W-1:0]   out_data_EB,
  output logic [$clog2(DEPTH):0]      fill_EB,
  output logic [7:0]                  ovf_cnt_EB
);

  localparam int unsigned EVT_W = evt_w(SEQ_W);
  localparam int unsigned FW    = $clog2(DEPTH) + 1;

  logic [SEQ_W-1:0] r_seq;
  logic [7:0]       r_ovf;
  logic             w_full;
  logic             w_pop;
  logic             w_sat;
  logic             w_accept;
  logic             w_push;
  logic             w_drop;
  logic [EVT_W-1:0] w_wdata;

`ifdef TDC_EB_SAT_FILTER_EN
  assign w_sat = (CountOutCC == COARSE_SAT);
`else
  assign w_sat = 1'b0;
`endif

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
  assign out_valid_EB = (fill_EB != '0);
  assign w_full       = (fill_EB == FW'(DEPTH));
  assign w_pop        = out_valid_EB & out_ready_EB & ~flush_EB;
  assign w_accept     = Valid_CC & ~flush_EB & ~w_sat;
  assign w_push       = w_accept & (~w_full | w_pop);
  assign w_drop       = w_accept & w_full & ~w_pop;
  assign w_wdata      = {r_seq, CountOutCC};

  // Every event consumes a sequence number, whether stored, dropped, filtered or flushed.
  always_ff @(posedge clk_EB or negedge reset_n_EB) begin
    if (!reset_n_EB) begin
      r_seq <= '0;
      r_ovf <= '0;
    end else begin
      if (Valid_CC) r_seq <= r_seq + SEQ_W'(1);
      if (w_drop && (r_ovf != 8'hFF)) r_ovf <= r_ovf + 8'd1;
    end
  end

  assign ovf_cnt_EB = r_ovf;

  tdc_eb_fifo #(
    .DEPTH (DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk     (clk_EB),
    .rst_n   (reset_n_EB),
    .i_flush (flush_EB),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (out_data_EB),
    .o_fill  (fill_EB)
  );

endmodule

// File: tb/tb_tdc_event_buffer.sv
// Randomized self-checking bench for tdc_event_buffer against a queue-based event model.
module tb_tdc_event_buffer;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [11:0] cnt;
  logic        flush;
  logic        ready;
  logic        out_valid;
  logic [19:0] out_data;
  logic [4:0]  fill;
  logic [7:0]  ovf;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  logic [19:0] mq[$];
  logic [19:0] got[$];
  int m_seq = 0;
  int m_ovf = 0;

  tdc_event_buffer #(.DEPTH(16), .SEQ_W(8)) dut (
    .clk_EB       (clk),
    .reset_n_EB   (rst_n),
    .Valid_CC     (valid),
    .CountOutCC   (cnt),
    .flush_EB     (flush),
    .out_valid_EB (out_valid),
    .out_ready_EB (ready),
    .out_data_EB  (out_data),
    .fill_EB      (fill),
    .ovf_cnt_EB   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit filtered(input logic [11:0] c);
`ifdef TDC_EB_SAT_FILTER_EN
    return c == 12'hFFF;
`else
    return 1'b0 && (c == 12'hFFF);
`endif
  endfunction

  // Model: an event queue plus sequence and overflow counters, applied per clock edge.
  task automatic model_edge(input logic v, input logic [11:0] c, input logic rdy, input logic fl);
    if (fl) begin
      mq.delete();
    end else begin
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (v && !filtered(c)) begin
        if (mq.size() < DEPTH) mq.push_back({8'(m_seq), c});
        else if (m_ovf < 255) m_ovf = m_ovf + 1;
      end
    end
    if (v) m_seq = (m_seq + 1) % 256;
  endtask

  task automatic model_clear();
    mq.delete();
    m_seq = 0;
    m_ovf = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("fill", 32'(fill), 32'(mq.size()));
      cmp("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      cmp("ovf_cnt", 32'(ovf), 32'(m_ovf));
      if (mq.size() != 0) cmp("out_data", 32'(out_data), 32'(mq[0]));
    end
  end

  task automatic cycle(input logic v, input logic [11:0] c, input logic rdy, input logic fl);
    valid = v;
    cnt   = c;
    ready = rdy;
    flush = fl;
    @(posedge clk);
    model_edge(v, c, rdy, fl);
    #1;
  endtask

  task automatic do_reset();
    valid = 0; cnt = '0; ready = 0; flush = 0;
    rst_n = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    cycle(0, 12'h0, 0, 0);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 0;
    model_clear();
    #1;
    cmp("async_rst_fill", 32'(fill), 32'd0);
    cmp("async_rst_valid", 32'(out_valid), 32'd0);
    cmp("async_rst_ovf", 32'(ovf), 32'd0);
    valid = 0; ready = 0; flush = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic drain();
    got.delete();
    for (int i = 0; i < 64 && out_valid; i++) begin
      got.push_back(out_data);
      cycle(0, 12'h0, 1, 0);
    end
    cmp("drain_empty", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int pv;
    int pr;
    valid = 0; cnt = '0; ready = 0; flush = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    cmp("reset_fill", 32'(fill), 32'd0);
    cmp("reset_valid", 32'(out_valid), 32'd0);
    cmp("reset_ovf", 32'(ovf), 32'd0);
    rst_n = 1;
    cycle(0, 12'h0, 0, 0);

    // Single event latency and handshake
    cycle(1, 12'h00A, 0, 0);
    cmp("single_valid", 32'(out_valid), 32'd1);
    cmp("single_data", 32'(out_data), 32'h0000A);
    cmp("single_fill", 32'(fill), 32'd1);
    cycle(0, 12'h0, 1, 0);
    cmp("single_popped", 32'(fill), 32'd0);

    // Fill past capacity, then drain in order
    do_reset();
    for (int i = 0; i < 18; i++) cycle(1, 12'(i), 0, 0);
    cmp("full_fill", 32'(fill), 32'd16);
    cmp("full_ovf", 32'(ovf), 32'd2);
    drain();
    cmp("drain_count", 32'(got.size()), 32'd16);
    for (int i = 0; i < got.size(); i++) cmp("drain_seq", 32'(got[i][19:12]), 32'(i));

    // Asynchronous reset mid-stream restarts sequencing
    for (int i = 0; i < 3; i++) cycle(1, 12'(i + 7), 0, 0);
    async_reset();
    cycle(1, 12'h123, 0, 0);
    cmp("post_rst_data", 32'(out_data), 32'h00123);
    cycle(0, 12'h0, 1, 0);

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1, 12'(i + 12'h100), 0, 0);
    cmp("full16_fill", 32'(fill), 32'd16);
    cycle(1, 12'h777, 1, 0);
    cmp("pushpop_fill", 32'(fill), 32'd16);
    cmp("pushpop_ovf", 32'(ovf), 32'd0);
    cmp("pushpop_head", 32'(out_data), 32'h01101);
    drain();
    cmp("pushpop_count", 32'(got.size()), 32'd16);
    cmp("pushpop_tail", 32'(got[got.size()-1]), 32'h10777);

    // Continuous streaming across sequence and pointer wrap
    do_reset();
    for (int i = 0; i < 300; i++) cycle(1, 12'(i), 1, 0);
    cmp("wrap_fill", 32'(fill), 32'd1);
    cmp("wrap_ovf", 32'(ovf), 32'd0);
    cmp("wrap_data", 32'(out_data), 32'h2B12B);
    drain();

    // Flush keeps sequencing; coincident event is lost but numbered
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 12'(i), 0, 0);
    cycle(0, 12'h0, 0, 1);
    cmp("flush_fill", 32'(fill), 32'd0);
    cycle(1, 12'h055, 0, 0);
    cmp("flush_next_seq", 32'(out_data), 32'h05055);
    cycle(1, 12'h066, 1, 1);
    cmp("flush_push_fill", 32'(fill), 32'd0);
    cycle(1, 12'h077, 0, 0);
    cmp("flush_skip_seq", 32'(out_data), 32'h07077);
    drain();

    // Saturated coarse count
    do_reset();
    cycle(1, 12'h005, 0, 0);
    cycle(1, 12'hFFF, 0, 0);
    cycle(1, 12'h006, 0, 0);
    drain();
`ifdef TDC_EB_SAT_FILTER_EN
    cmp("sat_count", 32'(got.size()), 32'd2);
    cmp("sat_next", 32'(got[1]), 32'h02006);
`else
    cmp("sat_count", 32'(got.size()), 32'd3);
    cmp("sat_stored", 32'(got[1]), 32'h01FFF);
    cmp("sat_next", 32'(got[2]), 32'h02006);
`endif

    // Randomized traffic with varying load
    do_reset();
    pv = 50; pr = 50;
    for (int i = 0; i < 4000; i++) begin
      logic [11:0] c;
      if (i % 400 == 0) begin
        pv = int'($urandom_range(100));
        pr = int'($urandom_range(100));
      end
      c = ($urandom_range(15) == 0) ? 12'hFFF : 12'($urandom);
      cycle(1'($urandom_range(99) < pv), c, 1'($urandom_range(99) < pr),
            1'($urandom_range(199) == 0));
      if ($urandom_range(999) == 0) async_reset();
    end
    drain();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
